// File: rtl/diff_amp_trim_ctrl.sv
// Offset-trim SAR sequencer and chopper phase generator for a differential amplifier bank.
// Channels are trimmed one at a time under auto-zero; the chopper runs only while idle.
module diff_amp_trim_ctrl #(
    parameter int N_CH       = 2,
    parameter int TRIM_W     = 6,
    parameter int SETTLE_W   = 8,
    parameter int CHOP_DIV_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ena,
    input  logic                   cal_start,
    input  logic [SETTLE_W-1:0]    settle_cyc,
    input  logic                   chop_en,
    input  logic [CHOP_DIV_W-1:0]  chop_div,
    input  logic [N_CH-1:0]        comp_in,
    output logic [N_CH-1:0]        az_sw,
    output logic [N_CH*TRIM_W-1:0] trim,
    output logic                   chop,
    output logic                   cal_busy,
    output logic                   cal_done,
    output logic [N_CH-1:0]        cal_err
);
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int BIT_W = $clog2(TRIM_W);
    localparam logic [CH_W-1:0]   LAST_CH = CH_W'(N_CH - 1);
    localparam logic [BIT_W-1:0]  TOP_BIT = BIT_W'(TRIM_W - 1);
    localparam logic [TRIM_W-1:0] MID     = {1'b1, {(TRIM_W-1){1'b0}}};
    localparam logic [TRIM_W-1:0] ONES    = {TRIM_W{1'b1}};

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        AZ_SETUP = 3'd1,
        SETTLE   = 3'd2,
        DECIDE   = 3'd3,
        NEXT_CH  = 3'd4
    } state_t;

    state_t                state_q;
    logic [N_CH-1:0]       comp_meta_q;
    logic [N_CH-1:0]       comp_sync_q;
    logic [CH_W-1:0]       ch_q;
    logic [BIT_W-1:0]      bit_q;
    logic [SETTLE_W-1:0]   settle_len_q;
    logic [SETTLE_W-1:0]   settle_cnt_q;
    logic [CHOP_DIV_W-1:0] chop_cnt_q;

    logic                  accept;
    logic                  chop_active;
    logic [SETTLE_W-1:0]   settle_len;
    logic [TRIM_W-1:0]     cur_trim;

    // Request handshake: cal_start is a one-cycle request, taken only on an edge where
    // the sequencer is IDLE and ena=1; cal_busy high means later requests are dropped.
    assign accept      = (state_q == IDLE) && ena && cal_start;
    assign chop_active = (state_q == IDLE) && ena && chop_en && !accept;
    assign settle_len  = (settle_cyc == '0) ? SETTLE_W'(1) : settle_cyc;
    assign cur_trim    = trim[int'(ch_q)*TRIM_W +: TRIM_W];

    // Comparator outputs are asynchronous to clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            comp_meta_q <= '0;
            comp_sync_q <= '0;
        end else begin
            comp_meta_q <= comp_in;
            comp_sync_q <= comp_meta_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            ch_q         <= '0;
            bit_q        <= '0;
            settle_len_q <= SETTLE_W'(1);
            settle_cnt_q <= '0;
            az_sw        <= '0;
            trim         <= {N_CH{MID}};
            cal_busy     <= 1'b0;
            cal_done     <= 1'b0;
            cal_err      <= '0;
        end else if (!ena) begin
            // Abort: trims and error flags keep whatever they hold now.
            state_q  <= IDLE;
            az_sw    <= '0;
            cal_busy <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cal_start) begin
                        ch_q         <= '0;
                        settle_len_q <= settle_len;
                        cal_busy     <= 1'b1;
                        cal_done     <= 1'b0;
                        cal_err      <= '0;
                        state_q      <= AZ_SETUP;
                    end
                end
                AZ_SETUP: begin
                    az_sw                                <= N_CH'(1) << ch_q;
                    trim[int'(ch_q)*TRIM_W +: TRIM_W]    <= MID;
                    bit_q                                <= TOP_BIT;
                    settle_cnt_q                         <= '0;
                    state_q                              <= SETTLE;
                end
                SETTLE: begin
                    if (settle_cnt_q == settle_len_q - 1'b1) begin
                        state_q <= DECIDE;
                    end else begin
                        settle_cnt_q <= settle_cnt_q + 1'b1;
                    end
                end
                DECIDE: begin
                    // Amp output positive means the trial bit overshoots: drop it.
                    if (comp_sync_q[ch_q]) begin
                        trim[int'(ch_q)*TRIM_W + int'(bit_q)] <= 1'b0;
                    end
                    if (bit_q != '0) begin
                        trim[int'(ch_q)*TRIM_W + int'(bit_q) - 1] <= 1'b1;
                        bit_q        <= bit_q - 1'b1;
                        settle_cnt_q <= '0;
                        state_q      <= SETTLE;
                    end else begin
                        state_q <= NEXT_CH;
                    end
                end
                NEXT_CH: begin
                    az_sw <= '0;
                    if (cur_trim == '0 || cur_trim == ONES) begin
                        cal_err[ch_q] <= 1'b1;
                    end
                    if (ch_q != LAST_CH) begin
                        ch_q    <= ch_q + 1'b1;
                        state_q <= AZ_SETUP;
                    end else begin
                        cal_busy <= 1'b0;
                        cal_done <= 1'b1;
                        state_q  <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Half-period is chop_div+1 cycles; the phase parks low whenever inactive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chop_cnt_q <= '0;
            chop       <= 1'b0;
        end else if (chop_active) begin
            if (chop_cnt_q == chop_div) begin
                chop_cnt_q <= '0;
                chop       <= ~chop;
            end else begin
                chop_cnt_q <= chop_cnt_q + 1'b1;
            end
        end else begin
            chop_cnt_q <= '0;
            chop       <= 1'b0;
        end
    end

endmodule

// File: tb/tb_diff_amp_trim_ctrl.sv
// Directed bench for diff_amp_trim_ctrl: table of calibration runs plus hand sequences
// for chopper timing, ena abort and asynchronous reset.
module tb_diff_amp_trim_ctrl;
    localparam int N_CH       = 2;
    localparam int TRIM_W     = 6;
    localparam int SETTLE_W   = 8;
    localparam int CHOP_DIV_W = 8;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   ena;
    logic                   cal_start;
    logic [SETTLE_W-1:0]    settle_cyc;
    logic                   chop_en;
    logic [CHOP_DIV_W-1:0]  chop_div;
    logic [N_CH-1:0]        comp_in;
    logic [N_CH-1:0]        az_sw;
    logic [N_CH*TRIM_W-1:0] trim;
    logic                   chop;
    logic                   cal_busy;
    logic                   cal_done;
    logic [N_CH-1:0]        cal_err;

    bit                     use_model;
    logic [1:0]             force_v;
    logic [5:0]             tgt [2];

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int         settle;
        bit         use_model;
        logic [1:0] force_v;
        logic [5:0] tgt0;
        logic [5:0] tgt1;
        int         restart_at;
        logic [5:0] exp0;
        logic [5:0] exp1;
        logic [1:0] exp_err;
        int         exp_lat;
    } vec_t;

    vec_t vecs [6];

    always #5 clk = ~clk;

    diff_amp_trim_ctrl #(
        .N_CH(N_CH), .TRIM_W(TRIM_W), .SETTLE_W(SETTLE_W), .CHOP_DIV_W(CHOP_DIV_W)
    ) dut (
        .clk(clk), .rst(rst), .ena(ena), .cal_start(cal_start),
        .settle_cyc(settle_cyc), .chop_en(chop_en), .chop_div(chop_div),
        .comp_in(comp_in), .az_sw(az_sw), .trim(trim), .chop(chop),
        .cal_busy(cal_busy), .cal_done(cal_done), .cal_err(cal_err)
    );

    // Comparator model: amp output positive when the trim word exceeds the target.
    always_comb begin
        comp_in = '0;
        for (int c = 0; c < N_CH; c++) begin
            comp_in[c] = use_model ? (trim[c*TRIM_W +: TRIM_W] > tgt[c]) : force_v[c];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic measure_toggle(output int n);
        logic start;
        start = chop;
        n = 0;
        do begin
            step();
            n++;
        end while (chop == start && n < 100);
    endtask

    task automatic run_row(input vec_t v, input int idx);
        int lat;
        bit az_bad, seen01, seen10, chop_seen, busy_drop;
        az_bad = 0; seen01 = 0; seen10 = 0; chop_seen = 0; busy_drop = 0;
        settle_cyc = SETTLE_W'(v.settle);
        use_model  = v.use_model;
        force_v    = v.force_v;
        tgt[0]     = v.tgt0;
        tgt[1]     = v.tgt1;
        cal_start  = 1'b1;
        step();
        cal_start  = 1'b0;
        check($sformatf("v%0d busy_at_accept", idx), cal_busy, 1);
        check($sformatf("v%0d done_cleared", idx), cal_done, 0);
        lat = 0;
        while (!cal_done && lat < 2000) begin
            if (az_sw == 2'b01) seen01 = 1;
            else if (az_sw == 2'b10) begin
                if (!seen01) az_bad = 1;
                seen10 = 1;
            end else if (az_sw != 2'b00) az_bad = 1;
            if (chop) chop_seen = 1;
            if (!cal_busy) busy_drop = 1;
            if (lat == v.restart_at) cal_start = 1'b1;
            step();
            cal_start = 1'b0;
            lat++;
        end
        check($sformatf("v%0d done_latency", idx), lat, v.exp_lat);
        check($sformatf("v%0d trim0", idx), trim[0 +: TRIM_W], v.exp0);
        check($sformatf("v%0d trim1", idx), trim[TRIM_W +: TRIM_W], v.exp1);
        check($sformatf("v%0d cal_err", idx), cal_err, v.exp_err);
        check($sformatf("v%0d busy_fall", idx), cal_busy, 0);
        check($sformatf("v%0d az_off", idx), az_sw, 0);
        check($sformatf("v%0d az_seq", idx), {az_bad, seen01, seen10}, 3'b011);
        check($sformatf("v%0d chop_quiet", idx), chop_seen, 0);
        check($sformatf("v%0d busy_steady", idx), busy_drop, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        bit found;
        vecs[0] = '{3, 1'b1, 2'b00, 6'd21, 6'd45, -1, 6'd21, 6'd45, 2'b00, 52};
        vecs[1] = '{3, 1'b0, 2'b01, 6'd0,  6'd0,  -1, 6'd0,  6'd63, 2'b11, 52};
        vecs[2] = '{0, 1'b0, 2'b10, 6'd0,  6'd0,  -1, 6'd63, 6'd0,  2'b11, 28};
        vecs[3] = '{2, 1'b1, 2'b00, 6'd1,  6'd62, -1, 6'd1,  6'd62, 2'b00, 40};
        vecs[4] = '{5, 1'b1, 2'b00, 6'd32, 6'd0,  -1, 6'd32, 6'd0,  2'b10, 76};
        vecs[5] = '{3, 1'b1, 2'b00, 6'd21, 6'd45, 10, 6'd21, 6'd45, 2'b00, 52};

        rst = 1'b1; ena = 1'b0; cal_start = 1'b0; settle_cyc = '0;
        chop_en = 1'b0; chop_div = '0; use_model = 1'b0; force_v = '0;
        tgt[0] = '0; tgt[1] = '0;
        step(); step();
        check("rst trim", trim, 12'h820);
        check("rst outputs", {az_sw, chop, cal_busy, cal_done, cal_err}, 0);
        rst = 1'b0;
        ena = 1'b1;
        step();
        check("post_rst trim", trim, 12'h820);
        check("post_rst busy", cal_busy, 0);

        for (int i = 0; i < 6; i++) begin
            run_row(vecs[i], i);
            step();
        end

        // Chopper in IDLE, held low through a calibration, then resumes.
        chop_div = 8'd4;
        chop_en  = 1'b1;
        measure_toggle(n);
        check("chop_first", n, 5);
        measure_toggle(n);
        check("chop_half2", n, 5);
        measure_toggle(n);
        check("chop_half3", n, 5);
        run_row(vecs[0], 10);
        measure_toggle(n);
        check("chop_resume", n, 5);
        chop_en = 1'b0;
        step();
        check("chop_off", chop, 0);

        // ena low blocks a start request.
        ena = 1'b0;
        cal_start = 1'b1;
        step();
        cal_start = 1'b0;
        check("ena0_no_start", cal_busy, 0);
        ena = 1'b1;
        step();

        // Abort during channel 1.
        settle_cyc = 8'd3; use_model = 1'b1; tgt[0] = 6'd21; tgt[1] = 6'd45;
        cal_start = 1'b1;
        step();
        cal_start = 1'b0;
        found = 0;
        for (int k = 0; k < 200 && !found; k++) begin
            if (az_sw == 2'b10) found = 1;
            else step();
        end
        check("abort reach_ch1", found, 1);
        step(); step(); step();
        ena = 1'b0;
        step();
        check("abort az_sw", az_sw, 0);
        check("abort busy", cal_busy, 0);
        check("abort done", cal_done, 0);
        check("abort trim0_kept", trim[0 +: TRIM_W], 21);
        check("abort err_kept", cal_err, 0);
        step();
        check("abort stays_idle", cal_busy, 0);
        ena = 1'b1;
        step();

        // Asynchronous reset while channel 1 sits in its first DECIDE.
        cal_start = 1'b1;
        step();
        cal_start = 1'b0;
        repeat (30) step();
        check("pre_rst az_sw", az_sw, 2'b10);
        check("pre_rst trim0", trim[0 +: TRIM_W], 21);
        #2 rst = 1'b1;
        #1;
        check("async_rst trim", trim, 12'h820);
        check("async_rst outputs", {az_sw, chop, cal_busy, cal_done, cal_err}, 0);
        @(negedge clk);
        rst = 1'b0;
        step();
        check("after_rst busy", cal_busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/diff_amp_trim_ctrl.md
Name: diff_amp_trim_ctrl

Overview:
Digital calibration and chopper sequencer for a bank of on-chip differential amplifiers.
- Runs a successive-approximation (SAR) offset-trim search on each channel in turn, using the amplifier's auto-zero switch and an analog comparator output.
- Generates a programmable chopper phase clock when not calibrating.
- Sits between the tile's digital I/O and the analog amplifier bank; trim words drive per-channel trim DACs.

Parameters:
N_CH, 2, number of amplifier channels (1..8)
TRIM_W, 6, trim DAC word width per channel (2..8)
SETTLE_W, 8, width of settle-count input
CHOP_DIV_W, 8, width of chopper divider input

Ports:
clk  input  1  system clock
rst  input  1  reset; one clock, reset asynchronous and active-high
ena  input  1  global enable; 0 aborts calibration and stops chopper
cal_start  input  1  single-cycle request to calibrate all channels
settle_cyc  input  SETTLE_W  settle cycles after each trim change (0 treated as 1)
chop_en  input  1  chopper enable
chop_div  input  CHOP_DIV_W  chopper half-period minus 1, in clk cycles
comp_in  input  N_CH  asynchronous comparator outputs, 1 = amp output positive
az_sw  output  N_CH  auto-zero switch enable, one-hot on channel under calibration
trim  output  N_CH*TRIM_W  trim words; channel c occupies bits [c*TRIM_W +: TRIM_W]
chop  output  1  chopper phase
cal_busy  output  1  calibration in progress
cal_done  output  1  sticky: last calibration completed
cal_err  output  N_CH  sticky per channel: final trim saturated (all-0 or all-1)

Behaviour:
- Reset (async, rst=1):
  - every trim = midscale (1<<(TRIM_W-1));
  - az_sw, chop, cal_busy, cal_done, cal_err = 0;
  - FSM = IDLE; synchroniser flops = 0.
- Input synchronisation: comp_in passes through a 2-flop synchroniser per bit. DECIDE uses the synchronised value only.
- All outputs are registered.
- Let S = max(settle_cyc, 1), sampled at the cal_start acceptance edge and held for the whole run.
- FSM states:
  - IDLE: cal_start=1 and ena=1 accepted on this edge. On acceptance: ch=0, cal_busy=1, cal_done=0, cal_err=0 -> AZ_SETUP.
  - AZ_SETUP (1 cycle): az_sw[ch]=1; trim[ch]=midscale; bit=TRIM_W-1 -> SETTLE.
  - SETTLE (S cycles): counter runs -> DECIDE.
  - DECIDE (1 cycle): if sync comp[ch]=1, clear trim[ch][bit]. If bit>0, set trim[ch][bit-1], bit-- -> SETTLE; else -> NEXT_CH.
  - NEXT_CH (1 cycle): az_sw=0. If trim[ch] is 0 or all-ones, set cal_err[ch]. If ch<N_CH-1, ch++ -> AZ_SETUP. Else -> IDLE with cal_busy=0, cal_done=1.
- Latency: cal_done rises N_CH*(TRIM_W*(S+1)+2) cycles after the acceptance edge; cal_busy falls on the same edge.
- cal_start while cal_busy=1: ignored, no restart.
- ena=0 in any state:
  - next edge -> IDLE; az_sw=0, cal_busy=0, cal_done stays 0;
  - trims retain their current values; cal_err is retained.
- Chopper:
  - Active only when FSM=IDLE, ena=1 and chop_en=1.
  - A counter counts 0..chop_div; chop toggles when the counter wraps, so the half-period is chop_div+1 cycles.
  - Otherwise chop=0 and the counter is held at 0.
  - First toggle occurs chop_div+1 cycles after the chopper becomes active.
- Async rst mid-calibration: immediate return to reset values, including midscale trims.

Test Plan:
1. Reset, N_CH=2, TRIM_W=6 -> trim=={6'd32,6'd32}; az_sw, chop, cal_busy, cal_done, cal_err all 0.
2. settle_cyc=3, comparator model comp[c]=(trim[c]>target[c]) with targets 21 and 45; pulse cal_start -> az_sw=2'b01 then 2'b10; final trims 21 and 45; cal_done rises exactly 52 cycles after the accept edge; cal_err=0.
3. comp forced 1 on ch0 and 0 on ch1 -> trims 0 and 63; cal_err=2'b11; cal_done=1.
4. chop_en=1, chop_div=4 in IDLE -> chop toggles every 5 cycles. Pulse cal_start -> chop=0 for the whole run, then resumes with its first toggle 5 cycles after cal_busy falls.
5. Pulse cal_start again at cycle 10 of a run -> no restart; done latency unchanged. Drop ena during ch1 -> next edge: az_sw=0, cal_busy=0, cal_done=0; ch0 trim retained.
6. Assert rst asynchronously mid-DECIDE -> all outputs reach reset values without a clock edge; trims back to 32.
